alu_pipe: RTL

- Parametrised successor to the single-cycle datapath ALU.
- Registered, handshaked execution unit for the processor datapath: add/sub with carry, even-parity, six-way compare for branch resolution, and an optional iterative multiplier.
- Sits between operand fetch and writeback.
- Operands are accepted with a valid/ready handshake. Results are held in a single output register until the consumer takes them.

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [2:0]       cond;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             compres;
    logic             carry;
    logic             err;

    modport master (
        output in_valid, op, cond, sgn, a, b, out_ready,
        input  in_ready, out_valid, result, compres, carry, err
    );

    modport slave (
        input  in_valid, op, cond, sgn, a, b, out_ready,
        output in_ready, out_valid, result, compres, carry, err
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU (add/sub/cmp/parity, optional shift-add MUL under ALU_PIPE_MUL_EN)
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       clock,
    input logic       reset_n,
    alu_pipe_if.slave io
);

    generate
        if (WIDTH < 4 || WIDTH > 64 || CNT_W != $clog2(WIDTH) + 1) begin : g_bad_param
            $error("alu_pipe: WIDTH must be 4..64 and CNT_W left at its derived value");
        end
    endgenerate

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             compres_q, compres_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic             in_ready;
    logic             accept;
    logic             is_mul;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             a_eq_b;
    logic             a_lt_b;
    logic [WIDTH-1:0] res_c;
    logic             cmp_c;
    logic             carry_c;
    logic             err_c;

`ifdef ALU_PIPE_MUL_EN
    // acc holds {partial high half, remaining multiplier bits}; it becomes the full product
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     step_sum;
`endif

    always_comb begin
        add_sum  = {1'b0, io.a} + {1'b0, io.b};
        sub_diff = {1'b0, io.a} - {1'b0, io.b};
        a_eq_b   = (io.a == io.b);
        a_lt_b   = io.sgn ? ($signed(io.a) < $signed(io.b)) : (io.a < io.b);
        res_c    = '0;
        cmp_c    = 1'b0;
        carry_c  = 1'b0;
        err_c    = 1'b0;
        case (io.op)
            3'b000: begin
                res_c   = add_sum[WIDTH-1:0];
                carry_c = add_sum[WIDTH];
            end
            3'b001: begin
                res_c   = sub_diff[WIDTH-1:0];
                carry_c = sub_diff[WIDTH];
            end
            3'b100: begin
                res_c = io.a;
                case (io.cond)
                    3'b000:  cmp_c = a_eq_b;
                    3'b001:  cmp_c = !a_eq_b;
                    3'b010:  cmp_c = a_lt_b;
                    3'b011:  cmp_c = !a_lt_b;
                    3'b100:  cmp_c = a_lt_b || a_eq_b;
                    3'b101:  cmp_c = !a_lt_b && !a_eq_b;
                    default: begin
                        res_c = '0;
                        err_c = 1'b1;
                    end
                endcase
            end
            3'b101:  res_c = {{(WIDTH-1){1'b0}}, ^io.a};
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = io.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = io.in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    assign is_mul   = (io.op == 3'b110);
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`else
    assign is_mul   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        compres_d = compres_q;
        carry_d   = carry_q;
        err_d     = err_q;
`ifdef ALU_PIPE_MUL_EN
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
`endif
        // accept is only possible from IDLE or a consuming DONE, so both share this path
        if (accept) begin
            if (is_mul) begin
`ifdef ALU_PIPE_MUL_EN
                state_d = S_BUSY;
                acc_d   = {{WIDTH{1'b0}}, io.b};
                mcand_d = io.a;
                cnt_d   = '0;
`endif
            end else begin
                state_d   = S_DONE;
                result_d  = res_c;
                compres_d = cmp_c;
                carry_d   = carry_c;
                err_d     = err_c;
            end
        end else begin
            case (state_q)
                S_DONE: begin
                    if (io.out_ready) state_d = S_IDLE;
                end
`ifdef ALU_PIPE_MUL_EN
                S_BUSY: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_d   = S_DONE;
                        result_d  = acc_q[WIDTH-1:0];
                        compres_d = 1'b0;
                        carry_d   = |acc_q[2*WIDTH-1:WIDTH];
                        err_d     = 1'b0;
                    end else begin
                        acc_d = {step_sum, acc_q[WIDTH-1:1]};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            compres_q <= 1'b0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            compres_q <= compres_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
`ifdef ALU_PIPE_MUL_EN
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
`endif
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = (state_q == S_DONE);
    assign io.result    = result_q;
    assign io.compres   = compres_q;
    assign io.carry     = carry_q;
    assign io.err       = err_q;

endmodule
